// File: rtl/vdp_super_vram_arb.sv
// rtl/vdp_super_vram_arb.sv - VRAM slot arbiter for super-res display fetch, refresh and CPU byte access
//
// Purpose: shares one 32-bit memory port between the super-res display fetch
// (slot phase 1 of every 4-pixel group), a once-per-line refresh at cx == 723,
// and byte-wide CPU reads/writes in the remaining windows.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   vdp_super, super_res_drawing  display slot enables
//   cx                            pixel column; cx[1:0] is the slot phase
//   super_res_vram_addr           display word address
//   vrm_32                        last display word fetched
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata, cpu_rdata/cpu_ack   CPU byte port
//   mem_rd/mem_wr/mem_refresh     one-hot memory command strobes
//   mem_addr/mem_wdata/mem_wmask  memory command payload
//   mem_rdata/mem_rd_valid        read return, one cycle after mem_rd
//
// Optional feature: define VDP_SUPER_POSTED_WRITE_EN to add a one-entry
// posted write buffer (CPU writes are acked before reaching memory).

module vdp_super_vram_arb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_super,
  input  logic [9:0]  cx,
  input  logic        super_res_drawing,
  input  logic [16:0] super_res_vram_addr,
  output logic [31:0] vrm_32,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_refresh,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rd_valid
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  state_t      state, state_nx;
  logic [1:0]  phase;
  logic        disp_slot;
  logic        refresh_slot;
  logic        disp_rd;
  logic        window;
  logic        disp_tag;      // the read returning this cycle belongs to the display
  logic        cpu_rd_issue;
  logic [1:0]  rd_lane;

`ifdef VDP_SUPER_POSTED_WRITE_EN
  logic        wb_valid;
  logic        wb_load;
  logic        wb_drain;
  logic [16:0] wb_addr;
  logic [7:0]  wb_data;
  logic [1:0]  wb_lane;
`endif

  assign phase        = cx[1:0];
  assign disp_slot    = vdp_super && super_res_drawing;
  assign refresh_slot = (cx == 10'd723);
  assign disp_rd      = disp_slot && (phase == 2'd1) && !refresh_slot;
  // While drawing, the CPU only gets phase 3; otherwise any free cycle.
  assign window       = !refresh_slot && !disp_rd && (!disp_slot || (phase == 2'd3));
  assign cpu_ack      = (state == ACK);

  always_comb begin
    state_nx     = state;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_refresh  = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    cpu_rd_issue = 1'b0;
`ifdef VDP_SUPER_POSTED_WRITE_EN
    wb_load      = 1'b0;
    wb_drain     = 1'b0;
`endif

    // Priority: refresh > display read > CPU (buffered write first).
    if (refresh_slot) begin
      mem_refresh = 1'b1;
    end else if (disp_rd) begin
      mem_rd   = 1'b1;
      mem_addr = super_res_vram_addr;
    end
`ifdef VDP_SUPER_POSTED_WRITE_EN
    else if (wb_valid && window) begin
      mem_wr    = 1'b1;
      mem_addr  = wb_addr;
      mem_wdata = {4{wb_data}};
      mem_wmask = 4'b0001 << wb_lane;
      wb_drain  = 1'b1;
    end else if ((state == IDLE) && cpu_req && !cpu_wr && window) begin
      mem_rd       = 1'b1;
      mem_addr     = cpu_addr[18:2];
      cpu_rd_issue = 1'b1;
    end
`else
    else if ((state == IDLE) && cpu_req && window) begin
      mem_addr = cpu_addr[18:2];
      if (cpu_wr) begin
        mem_wr    = 1'b1;
        mem_wdata = {4{cpu_wdata}};
        mem_wmask = 4'b0001 << cpu_addr[1:0];
      end else begin
        mem_rd       = 1'b1;
        cpu_rd_issue = 1'b1;
      end
    end
`endif

    case (state)
      IDLE: begin
        if (cpu_rd_issue) begin
          state_nx = RD_WAIT;
        end
`ifdef VDP_SUPER_POSTED_WRITE_EN
        else if (cpu_req && cpu_wr && !wb_valid) begin
          wb_load  = 1'b1;
          state_nx = ACK;
        end
`else
        else if (mem_wr) begin
          state_nx = ACK;
        end
`endif
      end
      RD_WAIT: begin
        if (mem_rd_valid && !disp_tag) begin
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Keep the memory quiet while reset is held, independent of cx.
    if (!reset_n) begin
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_refresh = 1'b0;
      mem_wmask   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vrm_32    <= '0;
      cpu_rdata <= '0;
      disp_tag  <= 1'b0;
      rd_lane   <= '0;
    end else begin
      state    <= state_nx;
      disp_tag <= disp_rd;
      if (disp_tag && mem_rd_valid) begin
        vrm_32 <= mem_rdata;
      end
      if (cpu_rd_issue) begin
        rd_lane <= cpu_addr[1:0];
      end
      if ((state == RD_WAIT) && mem_rd_valid && !disp_tag) begin
        cpu_rdata <= mem_rdata[{rd_lane, 3'b000} +: 8];
      end
    end
  end

`ifdef VDP_SUPER_POSTED_WRITE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_lane  <= '0;
    end else if (wb_load) begin
      wb_valid <= 1'b1;
      wb_addr  <= cpu_addr[18:2];
      wb_data  <= cpu_wdata;
      wb_lane  <= cpu_addr[1:0];
    end else if (wb_drain) begin
      wb_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vdp_super_vram_arb.sv
// tb/tb_vdp_super_vram_arb.sv - self-checking bench for vdp_super_vram_arb
module tb_vdp_super_vram_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdp_super = 1'b0;
  logic [9:0]  cx = '0;
  logic        super_res_drawing = 1'b0;
  logic [16:0] super_res_vram_addr = '0;
  logic [31:0] vrm_32;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        mem_rd, mem_wr, mem_refresh;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_rd_valid = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Sampled outputs of the current cycle.
  logic        s_rd, s_wr, s_ref, s_ack;
  logic [16:0] s_addr;
  logic [31:0] s_wdata, s_vrm;
  logic [3:0]  s_wmask;
  logic [7:0]  s_rdata;
  logic [9:0]  s_cx;

  // Reference model: memory contents and expected display word.
  logic [31:0] mem [int];
  logic        m_disp;
  logic [31:0] m_vrm = '0;
  logic [31:0] m_pend = '0;
  int          m_cnt = 0;

  vdp_super_vram_arb dut (
    .clk(clk), .reset_n(reset_n), .vdp_super(vdp_super), .cx(cx),
    .super_res_drawing(super_res_drawing), .super_res_vram_addr(super_res_vram_addr),
    .vrm_32(vrm_32), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_rd_valid(mem_rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd_word(input logic [16:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {15'h2B1D, a};
  endfunction

  // One clock cycle: sample outputs mid-cycle, let the memory model act on
  // the edge, then present the next cycle's inputs.
  task automatic cyc();
    @(negedge clk);
    s_rd = mem_rd; s_wr = mem_wr; s_ref = mem_refresh; s_ack = cpu_ack;
    s_addr = mem_addr; s_wdata = mem_wdata; s_wmask = mem_wmask;
    s_vrm = vrm_32; s_rdata = cpu_rdata; s_cx = cx;
    m_disp = reset_n && vdp_super && super_res_drawing && (cx[1:0] == 2'd1) && (cx != 10'd723);
    if (!reset_n) begin
      m_vrm = '0;
      m_cnt = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_vrm = m_pend;
      end
      if (m_disp) begin
        m_pend = rd_word(super_res_vram_addr);
        m_cnt = 2;
      end
    end
    @(posedge clk);
    if (s_wr) begin
      logic [31:0] w;
      w = rd_word(s_addr);
      for (int i = 0; i < 4; i++) if (s_wmask[i]) w[i*8 +: 8] = s_wdata[i*8 +: 8];
      mem[int'(s_addr)] = w;
    end
    #1;
    mem_rd_valid = s_rd;
    mem_rdata = s_rd ? rd_word(s_addr) : $urandom;
    cx = (cx == 10'd799) ? 10'd0 : cx + 10'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vdp_super = 1'b1; super_res_drawing = 1'b1; cx = 10'd1;
    cyc();
    n_checks++; if (s_rd !== 1'b0 || s_wr !== 1'b0 || s_ref !== 1'b0) begin n_fail++;
      $display("FAIL reset_strobes got rd=%b wr=%b ref=%b exp 000", s_rd, s_wr, s_ref); end
    n_checks++; if (s_wmask !== 4'b0 || s_ack !== 1'b0) begin n_fail++;
      $display("FAIL reset_mask_ack got wmask=%b ack=%b exp 0000/0", s_wmask, s_ack); end
    n_checks++; if (s_vrm !== 32'h0 || s_rdata !== 8'h0) begin n_fail++;
      $display("FAIL reset_data got vrm=%h rdata=%h exp 0/0", s_vrm, s_rdata); end
    cx = 10'd723;
    cyc();
    n_checks++; if (s_ref !== 1'b0) begin n_fail++;
      $display("FAIL reset_refresh got %b exp 0", s_ref); end
    reset_n = 1'b1;
  endtask

  task automatic test_display_read();
    vdp_super = 1'b1; super_res_drawing = 1'b1; super_res_vram_addr = 17'h00005;
    mem[5] = 32'hDEADBEEF; cpu_req = 1'b0; cx = 10'd0;
    cyc();
    n_checks++; if (s_rd !== 1'b0) begin n_fail++;
      $display("FAIL disp_phase0 got rd=%b exp 0", s_rd); end
    cyc();
    n_checks++; if (s_rd !== 1'b1 || s_addr !== 17'h00005) begin n_fail++;
      $display("FAIL disp_phase1 got rd=%b addr=%h exp 1/00005", s_rd, s_addr); end
    cyc();
    cyc();
    n_checks++; if (s_vrm !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL disp_vrm got %h exp deadbeef", s_vrm); end
  endtask

  task automatic test_refresh();
    vdp_super = 1'b0; super_res_drawing = 1'b0; cpu_req = 1'b0; cx = 10'd722;
    cyc();
    n_checks++; if (s_ref !== 1'b0) begin n_fail++;
      $display("FAIL ref_722 got %b exp 0", s_ref); end
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00100;
    cyc();
    n_checks++; if (s_ref !== 1'b1 || s_rd !== 1'b0) begin n_fail++;
      $display("FAIL ref_723 got ref=%b rd=%b exp 1/0", s_ref, s_rd); end
    cyc();
    n_checks++; if (s_ref !== 1'b0 || s_rd !== 1'b1 || s_addr !== 17'h00040) begin n_fail++;
      $display("FAIL ref_724_cpu got ref=%b rd=%b addr=%h exp 0/1/00040", s_ref, s_rd, s_addr); end
    cyc();
    cyc();
    n_checks++; if (s_ack !== 1'b1) begin n_fail++;
      $display("FAIL ref_cpu_ack got %b exp 1", s_ack); end
    cpu_req = 1'b0;
    cyc();
  endtask

`ifndef VDP_SUPER_POSTED_WRITE_EN
  task automatic test_cpu_write_drawing();
    vdp_super = 1'b1; super_res_drawing = 1'b1; super_res_vram_addr = 17'h00005;
    cx = 10'd0; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'h5A;
    for (int p = 0; p < 3; p++) begin
      cyc();
      n_checks++; if (s_wr !== 1'b0 || s_ack !== 1'b0) begin n_fail++;
        $display("FAIL wr_early phase=%0d got wr=%b ack=%b exp 0/0", p, s_wr, s_ack); end
    end
    cyc();
    n_checks++; if (s_wr !== 1'b1 || s_addr !== 17'h00001 || s_wmask !== 4'b0100 || s_wdata !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL wr_phase3 got wr=%b addr=%h mask=%b data=%h exp 1/00001/0100/5a5a5a5a", s_wr, s_addr, s_wmask, s_wdata);
    end
    cyc();
    n_checks++; if (s_ack !== 1'b1) begin n_fail++;
      $display("FAIL wr_ack got %b exp 1", s_ack); end
    cpu_req = 1'b0;
    cyc();
  endtask
`else
  task automatic test_posted_write();
    vdp_super = 1'b1; super_res_drawing = 1'b1; super_res_vram_addr = 17'h00005;
    cx = 10'd0; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h0000D; cpu_wdata = 8'h3C;
    cyc();
    n_checks++; if (s_ack !== 1'b0 || s_wr !== 1'b0) begin n_fail++;
      $display("FAIL post_p0 got ack=%b wr=%b exp 0/0", s_ack, s_wr); end
    cyc();
    n_checks++; if (s_ack !== 1'b1 || s_wr !== 1'b0) begin n_fail++;
      $display("FAIL post_ack got ack=%b wr=%b exp 1/0", s_ack, s_wr); end
    cpu_req = 1'b0;
    cyc();
    n_checks++; if (s_wr !== 1'b0) begin n_fail++;
      $display("FAIL post_p2 got wr=%b exp 0", s_wr); end
    cyc();
    n_checks++; if (s_wr !== 1'b1 || s_addr !== 17'h00003 || s_wmask !== 4'b0010 || s_wdata !== 32'h3C3C3C3C) begin
      n_fail++;
      $display("FAIL post_drain got wr=%b addr=%h mask=%b data=%h exp 1/00003/0010/3c3c3c3c", s_wr, s_addr, s_wmask, s_wdata);
    end
    cyc();
  endtask
`endif

  task automatic test_cpu_read_idle();
    vdp_super = 1'b1; super_res_drawing = 1'b0; mem[0] = 32'h11223344; cx = 10'd100;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00003;
    cyc();
    n_checks++; if (s_rd !== 1'b1 || s_addr !== 17'h0) begin n_fail++;
      $display("FAIL rd_issue got rd=%b addr=%h exp 1/00000", s_rd, s_addr); end
    cyc();
    n_checks++; if (s_ack !== 1'b0) begin n_fail++;
      $display("FAIL rd_early_ack got %b exp 0", s_ack); end
    cyc();
    n_checks++; if (s_ack !== 1'b1 || s_rdata !== 8'h11) begin n_fail++;
      $display("FAIL rd_ack got ack=%b rdata=%h exp 1/11", s_ack, s_rdata); end
    n_checks++; if (s_vrm !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL rd_vrm_kept got %h exp deadbeef", s_vrm); end
    cpu_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    vdp_super = 1'b0; super_res_drawing = 1'b0; cx = 10'd200;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00008;
    cyc();
    n_checks++; if (s_rd !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_issue got rd=%b exp 1", s_rd); end
    reset_n = 1'b0; cpu_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++; if (s_ack !== 1'b0 || s_rd !== 1'b0 || s_vrm !== 32'h0 || s_rdata !== 8'h0) begin n_fail++;
        $display("FAIL rstmid_hold got ack=%b rd=%b vrm=%h rdata=%h exp 0/0/0/0", s_ack, s_rd, s_vrm, s_rdata); end
    end
    reset_n = 1'b1;
    cyc();
    n_checks++; if (s_ack !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_no_ack got %b exp 0", s_ack); end
    mem[2] = 32'hCAFEF00D; cpu_req = 1'b1; cpu_addr = 19'h0000A;
    cyc();
    n_checks++; if (s_rd !== 1'b1 || s_addr !== 17'h00002) begin n_fail++;
      $display("FAIL rstmid_reissue got rd=%b addr=%h exp 1/00002", s_rd, s_addr); end
    cyc();
    cyc();
    n_checks++; if (s_ack !== 1'b1 || s_rdata !== 8'hFE) begin n_fail++;
      $display("FAIL rstmid_read got ack=%b rdata=%h exp 1/fe", s_ack, s_rdata); end
    cpu_req = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int t = 0; t < 150; t++) begin
      logic       wr;
      logic [18:0] a;
      logic [7:0] d, exp_b;
      logic [31:0] w;
      int cmd_at, ack_at;
      bit done;
      wr = 1'($urandom_range(0, 1)); a = 19'($urandom); d = 8'($urandom);
      vdp_super = 1'($urandom_range(0, 1)); super_res_drawing = ($urandom_range(0, 3) != 0);
      super_res_vram_addr = 17'($urandom_range(0, 63));
      cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      cmd_at = -1; ack_at = -1; done = 0; exp_b = '0;
      for (int c = 0; c < 40 && !done; c++) begin
        bit cmd, disp_on;
        cyc();
        disp_on = vdp_super && super_res_drawing;
        n_checks++; if ((int'(s_rd) + int'(s_wr) + int'(s_ref)) > 1) begin n_fail++;
          $display("FAIL rnd_onehot cx=%0d got rd=%b wr=%b ref=%b exp at most one", s_cx, s_rd, s_wr, s_ref); end
        n_checks++; if (s_ref !== (s_cx == 10'd723)) begin n_fail++;
          $display("FAIL rnd_refresh cx=%0d got %b exp %b", s_cx, s_ref, s_cx == 10'd723); end
        if (m_disp) begin
          n_checks++; if (s_rd !== 1'b1 || s_addr !== super_res_vram_addr) begin n_fail++;
            $display("FAIL rnd_disp cx=%0d got rd=%b addr=%h exp 1/%h", s_cx, s_rd, s_addr, super_res_vram_addr); end
        end
        n_checks++; if (s_vrm !== m_vrm) begin n_fail++;
          $display("FAIL rnd_vrm cx=%0d got %h exp %h", s_cx, s_vrm, m_vrm); end
        cmd = s_wr || (s_rd && !m_disp);
        if (cmd) begin
          n_checks++;
          if (cmd_at >= 0 || s_cx == 10'd723 || (disp_on && s_cx[1:0] != 2'd3) || s_addr !== a[18:2] || s_wr !== wr) begin
            n_fail++;
            $display("FAIL rnd_cmd cx=%0d got wr=%b addr=%h exp window wr=%b addr=%h", s_cx, s_wr, s_addr, wr, a[18:2]);
          end
          if (s_wr) begin
            n_checks++; if (s_wdata !== {4{d}} || s_wmask !== (4'b0001 << a[1:0])) begin n_fail++;
              $display("FAIL rnd_wdata got %h/%b exp %h/%b", s_wdata, s_wmask, {4{d}}, 4'b0001 << a[1:0]); end
          end else begin
            w = rd_word(s_addr);
            exp_b = w[{a[1:0], 3'b000} +: 8];
          end
          cmd_at = c;
        end
        if (s_ack) begin
          n_checks++;
`ifdef VDP_SUPER_POSTED_WRITE_EN
          if (ack_at >= 0 || (wr ? (c != 1) : (cmd_at < 0 || c != cmd_at + 2))) begin
`else
          if (ack_at >= 0 || cmd_at < 0 || c != cmd_at + (wr ? 1 : 2)) begin
`endif
            n_fail++;
            $display("FAIL rnd_ack_time got ack at %0d cmd at %0d wr=%b", c, cmd_at, wr);
          end
          if (!wr) begin
            n_checks++; if (s_rdata !== exp_b) begin n_fail++;
              $display("FAIL rnd_rdata got %h exp %h", s_rdata, exp_b); end
          end
          ack_at = c;
          cpu_req = 1'b0;
        end
        done = (ack_at >= 0) && (cmd_at >= 0);
      end
      n_checks++; if (!done) begin n_fail++;
        $display("FAIL rnd_timeout txn=%0d got cmd_at=%0d ack_at=%0d exp both", t, cmd_at, ack_at); end
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_display_read();
    test_refresh();
`ifndef VDP_SUPER_POSTED_WRITE_EN
    test_cpu_write_drawing();
`else
    test_posted_write();
`endif
    test_cpu_read_idle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
